// File: rtl/dmem_split_pkg.sv
// rtl/dmem_split_pkg.sv - shared size/state encodings and lane helpers for the split unit
package dmem_split_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE     = 2'd0,
        SIZE_HALF     = 2'd1,
        SIZE_WORD     = 2'd2,
        SIZE_WORD_ALT = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC0 = 2'd1,
        ST_ACC1 = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    function automatic logic [2:0] size_nbytes(input logic [1:0] size);
        case (size)
            SIZE_BYTE: return 3'd1;
            SIZE_HALF: return 3'd2;
            default:   return 3'd4;
        endcase
    endfunction

    // Lane enables for an access that starts at lane 0.
    function automatic logic [3:0] size_lanes(input logic [1:0] size);
        case (size)
            SIZE_BYTE: return 4'b0001;
            SIZE_HALF: return 4'b0011;
            default:   return 4'b1111;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SIZE_BYTE: return 1'b0;
            SIZE_HALF: return off[0];
            default:   return off != 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_ext.sv
// rtl/dmem_lane_ext.sv - merges the two fetched words into access order and extends to 32 bits
module dmem_lane_ext
    import dmem_split_pkg::*;
(
    input  logic [31:0] i_rdata0,
    input  logic [31:0] i_rdata1,
    input  logic [1:0]  i_off,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_data
);

    logic [63:0] w_shift;
    logic [31:0] w_merged;

    // Word pair shifted so the first accessed byte lands in lane 0; a non-crossing
    // access never reaches into the upper word, so stale i_rdata1 is harmless.
    assign w_shift  = {i_rdata1, i_rdata0} >> {i_off, 3'b000};
    assign w_merged = w_shift[31:0];

    always_comb begin
        o_data = w_merged;
        case (i_size)
            SIZE_BYTE: o_data = {{24{~i_unsigned & w_merged[7]}}, w_merged[7:0]};
            SIZE_HALF: o_data = {{16{~i_unsigned & w_merged[15]}}, w_merged[15:0]};
            default:   o_data = w_merged;
        endcase
    end

endmodule

// File: rtl/dmem_split_unit.sv
// rtl/dmem_split_unit.sv - load/store unit that splits word-crossing accesses into two aligned word accesses
module dmem_split_unit
    import dmem_split_pkg::*;
#(
    parameter bit SPLIT_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] dmem_addr,
    output logic        dmem_write,
    output logic [3:0]  dmem_wmask,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata
);

    state_e      r_state;
    state_e      w_next;
    logic [31:0] r_addr;
    logic        r_write;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [31:0] r_wdata;
    logic        r_err;
    logic [31:0] r_rd0;
    logic [31:0] r_rd1;

    logic [1:0]  w_off;
    logic [2:0]  w_nbytes;
    logic        w_cross;
    logic        w_reject;
    logic [7:0]  w_lanes8;
    logic [63:0] w_wdata64;
    logic [31:0] w_base;
    logic [31:0] w_ext;

    assign w_off    = r_addr[1:0];
    assign w_nbytes = size_nbytes(r_size);
    assign w_cross  = ({1'b0, w_off} + w_nbytes) > 3'd4;
    assign w_reject = !SPLIT_EN && is_misaligned(req_size, req_addr[1:0]);
    assign w_base   = {r_addr[31:2], 2'b00};

    // Lane masks and store data laid across an 8-lane window: the low half is the
    // first word, the high half is whatever spills into the following word.
    assign w_lanes8  = {4'b0000, size_lanes(r_size)} << w_off;
    assign w_wdata64 = {32'h0, r_wdata} << {w_off, 3'b000};

    dmem_lane_ext u_lane_ext (
        .i_rdata0   (r_rd0),
        .i_rdata1   (r_rd1),
        .i_off      (w_off),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .o_data     (w_ext)
    );

    assign req_ready  = (r_state == ST_IDLE) && rst_n;
    assign resp_valid = (r_state == ST_RESP);
    assign resp_err   = (r_state == ST_RESP) && r_err;
    assign resp_rdata = ((r_state == ST_RESP) && !r_err && !r_write) ? w_ext : 32'h0;

    always_comb begin
        w_next     = r_state;
        dmem_addr  = 32'h0;
        dmem_write = 1'b0;
        dmem_wmask = 4'h0;
        dmem_wdata = 32'h0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_next = w_reject ? ST_RESP : ST_ACC0;
                end
            end
            ST_ACC0: begin
                dmem_addr  = w_base;
                dmem_write = r_write;
                dmem_wmask = w_lanes8[3:0];
                dmem_wdata = w_wdata64[31:0];
                w_next     = w_cross ? ST_ACC1 : ST_RESP;
            end
            ST_ACC1: begin
                dmem_addr  = w_base + 32'd4;
                dmem_write = r_write;
                dmem_wmask = w_lanes8[7:4];
                dmem_wdata = w_wdata64[63:32];
                w_next     = ST_RESP;
            end
            ST_RESP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_addr     <= 32'h0;
            r_write    <= 1'b0;
            r_size     <= 2'd0;
            r_unsigned <= 1'b0;
            r_wdata    <= 32'h0;
            r_err      <= 1'b0;
            r_rd0      <= 32'h0;
            r_rd1      <= 32'h0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE && req_valid) begin
                r_addr     <= req_addr;
                r_write    <= req_write;
                r_size     <= req_size;
                r_unsigned <= req_unsigned;
                r_wdata    <= req_wdata;
                r_err      <= w_reject;
            end
            if (r_state == ST_ACC0) begin
                r_rd0 <= dmem_rdata;
            end
            if (r_state == ST_ACC1) begin
                r_rd1 <= dmem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_split_unit.sv
// tb/tb_dmem_split_unit.sv - self-checking bench for dmem_split_unit
module tb_dmem_split_unit;

    logic        clk;
    logic        rst_n;
    logic        mem_init;

    logic        req_valid, req_ready, req_write, req_unsigned;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        dmem_write;
    logic [3:0]  dmem_wmask;

    logic        z_req_valid, z_req_ready, z_req_write, z_req_unsigned;
    logic [31:0] z_req_addr, z_req_wdata;
    logic [1:0]  z_req_size;
    logic        z_resp_valid, z_resp_err;
    logic [31:0] z_resp_rdata;
    logic [31:0] z_dmem_addr, z_dmem_wdata, z_dmem_rdata;
    logic        z_dmem_write;
    logic [3:0]  z_dmem_wmask;

    logic [7:0]  mem    [0:1023];
    logic [7:0]  shadow [0:1023];

    int checks = 0;
    int errors = 0;

    dmem_split_unit #(.SPLIT_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .dmem_addr(dmem_addr), .dmem_write(dmem_write), .dmem_wmask(dmem_wmask),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata)
    );

    dmem_split_unit #(.SPLIT_EN(1'b0)) dut_nosplit (
        .clk(clk), .rst_n(rst_n),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_addr(z_req_addr),
        .req_write(z_req_write), .req_size(z_req_size), .req_unsigned(z_req_unsigned),
        .req_wdata(z_req_wdata),
        .resp_valid(z_resp_valid), .resp_rdata(z_resp_rdata), .resp_err(z_resp_err),
        .dmem_addr(z_dmem_addr), .dmem_write(z_dmem_write), .dmem_wmask(z_dmem_wmask),
        .dmem_wdata(z_dmem_wdata), .dmem_rdata(z_dmem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] init_byte(input int i);
        return 8'((i * 29 + 7) ^ (i >> 4));
    endfunction

    assign dmem_rdata = {mem[{dmem_addr[9:2], 2'd3}], mem[{dmem_addr[9:2], 2'd2}],
                         mem[{dmem_addr[9:2], 2'd1}], mem[{dmem_addr[9:2], 2'd0}]};
    assign z_dmem_rdata = 32'h8123_4567;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 1024; i++) mem[i] <= init_byte(i);
        end else if (dmem_write) begin
            for (int l = 0; l < 4; l++)
                if (dmem_wmask[l]) mem[{dmem_addr[9:2], 2'(l)}] <= dmem_wdata[8*l +: 8];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference: each byte addr+i goes to the word holding it; loads assemble from the
    // shadow image and extend, stores update the shadow image.
    task automatic run1(input logic [31:0] a, input logic [1:0] sz, input logic wr,
                        input logic uns, input logic [31:0] wd, output logic [31:0] got);
        int          n, lat, k, nacc;
        logic [31:0] eaddr [2];
        logic [3:0]  emask [2];
        logic [31:0] ewd   [2];
        logic [31:0] v;
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        nacc = ((int'(a[1:0]) + n) > 4) ? 2 : 1;
        eaddr[0] = a & 32'hFFFF_FFFC;
        eaddr[1] = eaddr[0] + 32'd4;
        emask[0] = 4'h0;
        emask[1] = 4'h0;
        ewd[0]   = wd << (8 * int'(a[1:0]));
        ewd[1]   = (a[1:0] == 2'd0) ? 32'h0 : wd >> (32 - 8 * int'(a[1:0]));
        v = 32'h0;
        for (int i = 0; i < n; i++) begin
            logic [31:0] ba;
            ba = a + 32'(i);
            if (ba[31:2] == a[31:2]) emask[0][ba[1:0]] = 1'b1;
            else                     emask[1][ba[1:0]] = 1'b1;
            v = v | (32'(shadow[ba[9:0]]) << (8 * i));
            if (wr) shadow[ba[9:0]] = wd[8*i +: 8];
        end
        if (!uns && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
        if (!uns && n == 2 && v[15]) v = v | 32'hFFFF_0000;
        if (wr) v = 32'h0;

        @(negedge clk);
        req_addr = a; req_size = sz; req_write = wr; req_unsigned = uns; req_wdata = wd;
        req_valid = 1'b1;
        chk("ready_idle", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_addr = $urandom; req_wdata = $urandom;
        req_size = 2'($urandom); req_write = 1'($urandom); req_unsigned = 1'($urandom);
        lat = 1;
        k = 0;
        while (resp_valid !== 1'b1 && lat < 8) begin
            if (k < nacc) begin
                chk("acc_addr",  dmem_addr, eaddr[k]);
                chk("acc_write", 32'(dmem_write), 32'(wr));
                chk("acc_wmask", 32'(dmem_wmask), 32'(emask[k]));
                chk("acc_wdata", dmem_wdata, ewd[k]);
                k++;
            end
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 32'(lat), 32'(1 + nacc));
        chk("resp_valid", 32'(resp_valid), 32'd1);
        chk("resp_err", 32'(resp_err), 32'd0);
        chk("resp_rdata", resp_rdata, v);
        chk("resp_bus_idle", dmem_addr | dmem_wdata | {27'h0, dmem_write, dmem_wmask}, 32'h0);
        got = resp_rdata;
        @(posedge clk); #1;
        chk("resp_one_cycle", 32'(resp_valid), 32'd0);
        chk("ready_after", 32'(req_ready), 32'd1);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  size;
        logic        wr;
        logic        uns;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    initial begin
        vec_t        vecs [8];
        logic [31:0] got;
        int          lat;
        logic        acc;

        vecs[0] = '{32'h101, 2'd2, 1'b0, 1'b0, 1'b1, 32'h0,         1};
        vecs[1] = '{32'h103, 2'd1, 1'b0, 1'b0, 1'b1, 32'h0,         1};
        vecs[2] = '{32'h102, 2'd1, 1'b0, 1'b0, 1'b0, 32'hFFFF_8123, 2};
        vecs[3] = '{32'h101, 2'd0, 1'b0, 1'b1, 1'b0, 32'h0000_0045, 2};
        vecs[4] = '{32'h104, 2'd3, 1'b0, 1'b0, 1'b0, 32'h8123_4567, 2};
        vecs[5] = '{32'h102, 2'd2, 1'b1, 1'b0, 1'b1, 32'h0,         1};
        vecs[6] = '{32'h103, 2'd0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FF81, 2};
        vecs[7] = '{32'h001, 2'd1, 1'b0, 1'b1, 1'b1, 32'h0,         1};

        rst_n = 1'b0; mem_init = 1'b1;
        req_valid = 1'b0; req_addr = 32'h0; req_write = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_wdata = 32'h0;
        z_req_valid = 1'b0; z_req_addr = 32'h0; z_req_write = 1'b0; z_req_size = 2'd0;
        z_req_unsigned = 1'b0; z_req_wdata = 32'h0;
        for (int i = 0; i < 1024; i++) shadow[i] = init_byte(i);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_resp", {resp_rdata[31:2], resp_valid, resp_err} | resp_rdata, 32'h0);
        chk("rst_bus", dmem_addr | dmem_wdata | {27'h0, dmem_write, dmem_wmask}, 32'h0);
        mem_init = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_ready", 32'(req_ready), 32'd1);
        chk("rel_ready_nosplit", 32'(z_req_ready), 32'd1);

        run1(32'h100, 2'd2, 1'b1, 1'b0, 32'hDEAD_BEEF, got);
        run1(32'h100, 2'd2, 1'b0, 1'b0, 32'h0, got);
        chk("word_store_load", got, 32'hDEAD_BEEF);

        run1(32'h103, 2'd0, 1'b1, 1'b0, 32'h0000_0080, got);
        run1(32'h103, 2'd0, 1'b0, 1'b0, 32'h0, got);
        chk("byte_signed", got, 32'hFFFF_FF80);
        run1(32'h103, 2'd0, 1'b0, 1'b1, 32'h0, got);
        chk("byte_unsigned", got, 32'h0000_0080);

        run1(32'h102, 2'd2, 1'b1, 1'b0, 32'h1122_3344, got);
        run1(32'h100, 2'd2, 1'b0, 1'b1, 32'h0, got);
        chk("cross_store_lo", got, 32'h3344_0080 | 32'h0000_BE00 | 32'h0000_00EF);

        run1(32'h1FF, 2'd0, 1'b1, 1'b0, 32'h34, got);
        run1(32'h200, 2'd0, 1'b1, 1'b0, 32'h92, got);
        run1(32'h1FF, 2'd1, 1'b0, 1'b0, 32'h0, got);
        chk("cross_half_signed", got, 32'hFFFF_9234);

        run1(32'hFFFF_FFFE, 2'd2, 1'b1, 1'b0, 32'hCAFE_F00D, got);
        run1(32'hFFFF_FFFE, 2'd2, 1'b0, 1'b0, 32'h0, got);
        chk("wrap_word", got, 32'hCAFE_F00D);

        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            z_req_addr = vecs[t].addr; z_req_size = vecs[t].size; z_req_write = vecs[t].wr;
            z_req_unsigned = vecs[t].uns; z_req_wdata = 32'h5555_AAAA;
            z_req_valid = 1'b1;
            @(posedge clk); #1;
            z_req_valid = 1'b0;
            lat = 1;
            acc = 1'b0;
            while (z_resp_valid !== 1'b1 && lat < 8) begin
                acc = acc | (z_dmem_wmask != 4'h0) | z_dmem_write;
                @(posedge clk); #1;
                lat++;
            end
            chk("ns_latency", 32'(lat), 32'(vecs[t].exp_lat));
            chk("ns_err", 32'(z_resp_err), 32'(vecs[t].exp_err));
            chk("ns_rdata", z_resp_rdata, vecs[t].exp_rdata);
            chk("ns_mem_touched", 32'(acc), 32'(!vecs[t].exp_err));
            @(posedge clk); #1;
        end

        // Reset while the second half of a crossing store is on the bus.
        @(negedge clk);
        req_addr = 32'h102; req_size = 2'd2; req_write = 1'b1; req_unsigned = 1'b0;
        req_wdata = 32'hAABB_CCDD; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("abort_acc0_mask", 32'(dmem_wmask), 32'hC);
        @(posedge clk); #1;
        chk("abort_acc1_addr", dmem_addr, 32'h104);
        shadow[10'h102] = 8'hDD;
        shadow[10'h103] = 8'hCC;
        rst_n = 1'b0;
        #1;
        chk("abort_bus", dmem_addr | dmem_wdata | {27'h0, dmem_write, dmem_wmask}, 32'h0);
        chk("abort_resp", {resp_rdata[31:2], resp_valid, resp_err} | resp_rdata, 32'h0);
        chk("abort_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("abort_rel_ready", 32'(req_ready), 32'd1);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("abort_no_resp", 32'(resp_valid), 32'd0);
        end
        run1(32'h102, 2'd1, 1'b0, 1'b0, 32'h0, got);
        chk("abort_first_half", got, 32'hFFFF_CCDD);
        run1(32'h104, 2'd2, 1'b0, 1'b0, 32'h0, got);

        for (int r = 0; r < 200; r++) begin
            logic [31:0] a;
            if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
            else                           a = 32'h300 + 32'($urandom_range(0, 63));
            run1(a, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), $urandom, got);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
